// File: rtl/lcd_page_sched_pkg.sv
// Shared types and constants for the LCD page scheduler: row geometry,
// power-up row text and the scheduler state encoding.
package lcd_pkg;

  localparam int CHARS_PER_ROW = 16;
  localparam int ROW_W         = CHARS_PER_ROW * 8;

  // Sixteen '?' characters shown until the first real frame is latched.
  localparam logic [ROW_W-1:0] ROW_INIT = {CHARS_PER_ROW{8'h3F}};

  typedef enum logic {
    ROTATE = 1'b0,
    MSG    = 1'b1
  } sched_state_t;

  // Width of a counter or pointer that must hold values 0..n-1; never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_page_sched_if.sv
// Message request bus between the text requesters and the page scheduler:
// level requests with per-requester row text, and a one-cycle grant pulse.
interface lcd_page_sched_if #(
  parameter int NREQ = 2
);
  import lcd_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ*ROW_W-1:0] req_row_a;
  logic [NREQ*ROW_W-1:0] req_row_b;
  logic [NREQ-1:0]       ack;

  modport master (output req, output req_row_a, output req_row_b, input ack);
  modport slave  (input req, input req_row_a, input req_row_b, output ack);

endinterface

// File: rtl/lcd_page_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping around. The pointer itself lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic            o_any,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx
);

  int w_base;

  // NOTE: every output gets a default before the search loop; a missing
  // default on any path of an always_comb would infer a latch.
  always_comb begin
    o_any   = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    w_base  = int'(i_ptr) % NREQ;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!o_any && i_req[j] && (j == (w_base + k) % NREQ)) begin
          o_any      = 1'b1;
          o_grant[j] = 1'b1;
          o_idx      = PW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/lcd_page_sched.sv
// Owns the LCD text rows: rotates the status/score pages and overlays
// round-robin granted full-screen messages for a fixed display time.
module lcd_page_sched
  import lcd_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int ROTATE_CYC = 100_000_000,
  parameter int MSG_CYC    = 75_000_000
) (
  input  logic             clk_50MHz,
  input  logic             reset_n,
  input  logic [ROW_W-1:0] stat_row_a,
  input  logic [ROW_W-1:0] stat_row_b,
  input  logic [ROW_W-1:0] score_row_a,
  input  logic [ROW_W-1:0] score_row_b,
  input  logic             hold_sw,
  lcd_page_sched_if.slave  msg_if,
  output logic [ROW_W-1:0] row_A,
  output logic [ROW_W-1:0] row_B,
  output logic             page,
  output logic             msg_active
);

  localparam int RW = cnt_w(ROTATE_CYC);
  localparam int MW = cnt_w(MSG_CYC);
  localparam int PW = cnt_w(NREQ);

  localparam logic [RW-1:0] ROT_LAST = RW'(ROTATE_CYC - 1);
  localparam logic [MW-1:0] MSG_LAST = MW'(MSG_CYC - 1);

  sched_state_t     r_state;
  logic [RW-1:0]    r_rot_cnt;
  logic [MW-1:0]    r_msg_cnt;
  logic [PW-1:0]    r_rr_ptr;
  logic [ROW_W-1:0] r_row_a;
  logic [ROW_W-1:0] r_row_b;
  logic             r_page;
  logic             r_msg_active;

  logic             w_any;
  logic [NREQ-1:0]  w_grant;
  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_ptr_next;
  logic             w_grant_ok;
  logic [ROW_W-1:0] w_page_a;
  logic [ROW_W-1:0] w_page_b;
  logic [ROW_W-1:0] w_req_a;
  logic [ROW_W-1:0] w_req_b;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .i_req   (msg_if.req),
    .i_ptr   (r_rr_ptr),
    .o_any   (w_any),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // Grants happen any cycle in ROTATE, or only on the last cycle of a
  // message; a reset cycle never grants so no requester loses its text.
  assign w_grant_ok = reset_n && w_any && ((r_state == ROTATE) || (r_msg_cnt == MSG_LAST));
  assign msg_if.ack = w_grant_ok ? w_grant : '0;

  assign w_ptr_next = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);
  assign w_page_a   = r_page ? score_row_a : stat_row_a;
  assign w_page_b   = r_page ? score_row_b : stat_row_b;

  always_comb begin
    w_req_a = '0;
    w_req_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant[k]) begin
        w_req_a = w_req_a | msg_if.req_row_a[k*ROW_W +: ROW_W];
        w_req_b = w_req_b | msg_if.req_row_b[k*ROW_W +: ROW_W];
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; reset is sampled on the clock edge only.
  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      r_state      <= ROTATE;
      r_rot_cnt    <= '0;
      r_msg_cnt    <= '0;
      r_rr_ptr     <= '0;
      r_row_a      <= ROW_INIT;
      r_row_b      <= ROW_INIT;
      r_page       <= 1'b0;
      r_msg_active <= 1'b0;
    end else if (w_grant_ok) begin
      // A grant wins over a coinciding page expiry and restarts rotation.
      r_state      <= MSG;
      r_row_a      <= w_req_a;
      r_row_b      <= w_req_b;
      r_msg_active <= 1'b1;
      r_msg_cnt    <= '0;
      r_rot_cnt    <= '0;
      r_rr_ptr     <= w_ptr_next;
    end else begin
      case (r_state)
        ROTATE: begin
          r_row_a <= w_page_a;
          r_row_b <= w_page_b;
          if (!hold_sw) begin
            if (r_rot_cnt == ROT_LAST) begin
              r_rot_cnt <= '0;
              r_page    <= ~r_page;
            end else begin
              r_rot_cnt <= r_rot_cnt + RW'(1);
            end
          end
        end
        MSG: begin
          r_rot_cnt <= '0;
          if (r_msg_cnt == MSG_LAST) begin
            r_state      <= ROTATE;
            r_row_a      <= w_page_a;
            r_row_b      <= w_page_b;
            r_msg_active <= 1'b0;
            r_msg_cnt    <= '0;
          end else begin
            r_msg_cnt <= r_msg_cnt + MW'(1);
          end
        end
      endcase
    end
  end

  assign row_A      = r_row_a;
  assign row_B      = r_row_b;
  assign page       = r_page;
  assign msg_active = r_msg_active;

endmodule

// File: tb/tb_lcd_page_sched.sv
// Scenario bench for lcd_page_sched: per-cycle expectations are queued as
// stimulus is applied and compared against the DUT at the falling edge.
module tb_lcd_page_sched;
  import lcd_pkg::*;

  localparam int NREQ = 2;
  localparam int ROT  = 8;
  localparam int MSGC = 5;

  logic             clk_50MHz = 1'b0;
  logic             reset_n   = 1'b0;
  logic [ROW_W-1:0] stat_row_a, stat_row_b, score_row_a, score_row_b;
  logic             hold_sw   = 1'b0;
  logic [ROW_W-1:0] row_A, row_B;
  logic             page, msg_active;

  logic [ROW_W-1:0] msg0_a, msg0_b, msg1_a, msg1_b, junk;

  lcd_page_sched_if #(.NREQ(NREQ)) msg_if ();

  lcd_page_sched #(
    .NREQ       (NREQ),
    .ROTATE_CYC (ROT),
    .MSG_CYC    (MSGC)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .reset_n     (reset_n),
    .stat_row_a  (stat_row_a),
    .stat_row_b  (stat_row_b),
    .score_row_a (score_row_a),
    .score_row_b (score_row_b),
    .hold_sw     (hold_sw),
    .msg_if      (msg_if),
    .row_A       (row_A),
    .row_B       (row_B),
    .page        (page),
    .msg_active  (msg_active)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  typedef struct {
    string            tag;
    logic [ROW_W-1:0] a;
    logic [ROW_W-1:0] b;
    logic             pg;
    logic             ma;
    logic [NREQ-1:0]  ak;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [ROW_W-1:0] pad16(input string s);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < CHARS_PER_ROW; i++)
      r[ROW_W-1-8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  task automatic expect_cycle(input string tag, input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b,
                              input logic pg, input logic ma, input logic [NREQ-1:0] ak);
    exp_t e;
    e.tag = tag; e.a = a; e.b = b; e.pg = pg; e.ma = ma; e.ak = ak;
    sb.push_back(e);
  endtask

  // Samples the current cycle at the falling edge, then advances to just
  // after the next rising edge where the following cycle's inputs are set.
  task automatic tick();
    exp_t e;
    @(negedge clk_50MHz);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: no expectation queued at %0t", $time);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (row_A !== e.a) begin
        n_fail++;
        $display("FAIL %s row_A: got %h want %h", e.tag, row_A, e.a);
      end
      n_checks++;
      if (row_B !== e.b) begin
        n_fail++;
        $display("FAIL %s row_B: got %h want %h", e.tag, row_B, e.b);
      end
      n_checks++;
      if (page !== e.pg) begin
        n_fail++;
        $display("FAIL %s page: got %b want %b", e.tag, page, e.pg);
      end
      n_checks++;
      if (msg_active !== e.ma) begin
        n_fail++;
        $display("FAIL %s msg_active: got %b want %b", e.tag, msg_active, e.ma);
      end
      n_checks++;
      if (msg_if.ack !== e.ak) begin
        n_fail++;
        $display("FAIL %s ack: got %b want %b", e.tag, msg_if.ack, e.ak);
      end
    end
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic do_reset();
    hold_sw    = 1'b0;
    msg_if.req = '0;
    reset_n    = 1'b0;
    repeat (2) begin
      @(posedge clk_50MHz);
      #1;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    msg_if.req = '0;
    @(posedge clk_50MHz);
    #1;
    for (int i = 0; i < 3; i++) begin
      expect_cycle("reset_hold", ROW_INIT, ROW_INIT, 1'b0, 1'b0, 2'b00);
      tick();
    end
    reset_n = 1'b1;
    expect_cycle("reset_release", ROW_INIT, ROW_INIT, 1'b0, 1'b0, 2'b00);
    tick();
    expect_cycle("reset_first_frame", stat_row_a, stat_row_b, 1'b0, 1'b0, 2'b00);
    tick();
  endtask

  task automatic test_rotation();
    logic pg, prev;
    do_reset();
    for (int k = 0; k <= 18; k++) begin
      pg   = ((k / ROT) % 2) == 1;
      prev = (k > 0) && ((((k - 1) / ROT) % 2) == 1);
      if (k == 0)
        expect_cycle("rotate", ROW_INIT, ROW_INIT, pg, 1'b0, 2'b00);
      else
        expect_cycle("rotate", prev ? score_row_a : stat_row_a, prev ? score_row_b : stat_row_b,
                     pg, 1'b0, 2'b00);
      tick();
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int k = 0; k <= 19; k++) begin
      hold_sw = (k >= 4) && (k <= 13);
      if (k == 0)
        expect_cycle("hold", ROW_INIT, ROW_INIT, 1'b0, 1'b0, 2'b00);
      else if (k <= 18)
        expect_cycle("hold", stat_row_a, stat_row_b, k >= 18, 1'b0, 2'b00);
      else
        expect_cycle("hold", score_row_a, score_row_b, 1'b1, 1'b0, 2'b00);
      tick();
    end
    hold_sw = 1'b0;
  endtask

  task automatic test_single_req();
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      msg_if.req = (k == 2) ? 2'b01 : 2'b00;
      // Text changes after capture must not reach the display.
      msg_if.req_row_a = (k >= 3) ? {msg1_a, junk} : {msg1_a, msg0_a};
      if (k == 0)
        expect_cycle("single_req", ROW_INIT, ROW_INIT, 1'b0, 1'b0, 2'b00);
      else if (k <= 2)
        expect_cycle("single_req", stat_row_a, stat_row_b, 1'b0, 1'b0, (k == 2) ? 2'b01 : 2'b00);
      else if (k <= 7)
        expect_cycle("single_msg", msg0_a, msg0_b, 1'b0, 1'b1, 2'b00);
      else
        expect_cycle("single_return", stat_row_a, stat_row_b, k == 16, 1'b0, 2'b00);
      tick();
    end
    msg_if.req_row_a = {msg1_a, msg0_a};
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      if (k == 0 || k == 12) msg_if.req = 2'b11;
      else if (k <= 5)       msg_if.req = 2'b10;
      else                   msg_if.req = 2'b00;
      if (k == 0)
        expect_cycle("b2b_grant0", ROW_INIT, ROW_INIT, 1'b0, 1'b0, 2'b01);
      else if (k <= 5)
        expect_cycle("b2b_msg0", msg0_a, msg0_b, 1'b0, 1'b1, (k == 5) ? 2'b10 : 2'b00);
      else if (k <= 10)
        expect_cycle("b2b_msg1", msg1_a, msg1_b, 1'b0, 1'b1, 2'b00);
      else
        expect_cycle("b2b_ptr_wrap", stat_row_a, stat_row_b, 1'b0, 1'b0, (k == 12) ? 2'b01 : 2'b00);
      tick();
    end
    msg_if.req = '0;
  endtask

  task automatic test_reset_mid_msg();
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      msg_if.req = (k == 1 || k == 5) ? 2'b00 : 2'b01;
      reset_n    = !(k == 2 || k == 3);
      case (k)
        0:       expect_cycle("rst_msg_grant", ROW_INIT, ROW_INIT, 1'b0, 1'b0, 2'b01);
        1, 2:    expect_cycle("rst_msg_shown", msg0_a, msg0_b, 1'b0, 1'b1, 2'b00);
        3:       expect_cycle("rst_msg_abort", ROW_INIT, ROW_INIT, 1'b0, 1'b0, 2'b00);
        4:       expect_cycle("rst_msg_regrant", ROW_INIT, ROW_INIT, 1'b0, 1'b0, 2'b01);
        default: expect_cycle("rst_msg_after", msg0_a, msg0_b, 1'b0, 1'b1, 2'b00);
      endcase
      tick();
    end
    reset_n    = 1'b1;
    msg_if.req = '0;
  endtask

  initial begin
    stat_row_a  = pad16("STAT");
    stat_row_b  = pad16("S=3 C=A5");
    score_row_a = pad16("SCORE");
    score_row_b = pad16("0042");
    msg0_a      = pad16("GAME OVER");
    msg0_b      = pad16("PRESS START");
    msg1_a      = pad16("PAUSED");
    msg1_b      = pad16("HOLD TO RESUME");
    junk        = pad16("JUNK TEXT");
    msg_if.req       = '0;
    msg_if.req_row_a = {msg1_a, msg0_a};
    msg_if.req_row_b = {msg1_b, msg0_b};

    test_reset();
    test_rotation();
    test_hold();
    test_single_req();
    test_back_to_back();
    test_reset_mid_msg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/lcd_page_sched.md
Name: lcd_page_sched

Overview:
- Scheduler/arbiter that owns the 16x2 character LCD text buffer (row_A/row_B feeding LCD_module).
- Rotates between two live pages: page 0 = game status (state/ctrl hex), page 1 = score.
- Grants transient full-screen messages (e.g. "GAME OVER", "PAUSED") from NREQ requesters, round-robin, each shown for a fixed time.
- Sits between the top-level text formatters and LCD_module, replacing direct row_A/row_B assignment in the top level.

Parameters:
- NREQ, 2, number of message requesters (1..4).
- ROTATE_CYC, 100_000_000, clk_50MHz cycles per live page (2 s).
- MSG_CYC, 75_000_000, clk_50MHz cycles a granted message is displayed (1.5 s).

Ports:
- clk_50MHz  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- stat_row_a  in  128  page 0 top-row text, 16 ASCII chars, MSB = leftmost.
- stat_row_b  in  128  page 0 bottom-row text.
- score_row_a  in  128  page 1 top-row text.
- score_row_b  in  128  page 1 bottom-row text.
- hold_sw  in  1  1 = freeze page rotation.
- req  in  NREQ  message request per requester, level, held until ack.
- req_row_a  in  NREQ*128  message top row; slice i belongs to requester i.
- req_row_b  in  NREQ*128  message bottom row.
- ack  out  NREQ  one-cycle grant pulse; message text captured on the same edge.
- row_A  out  128  registered LCD top row.
- row_B  out  128  registered LCD bottom row.
- page  out  1  current live page index.
- msg_active  out  1  1 while a message is displayed.

Behaviour:
- Reset is synchronous (reset_n low at a clk_50MHz edge). It sets:
  - row_A = row_B = ROW_INIT (16 x "?").
  - page = 0, ack = 0, msg_active = 0.
  - state = ROTATE, rot_cnt = 0, msg_cnt = 0, rr_ptr = 0.
- Reset mid-message aborts the message immediately. No ack is issued on the reset cycle.
- States: ROTATE, MSG.
- ROTATE:
  - Each cycle, row_A/row_B <= selected page rows. Latency is 1 cycle from input change to output.
  - rot_cnt increments when hold_sw = 0 and holds when hold_sw = 1.
  - At rot_cnt == ROTATE_CYC-1: rot_cnt <= 0 and page <= ~page.
- Arbitration, evaluated every cycle in ROTATE:
  - If any req is set, grant the first set bit searching from rr_ptr upward, with wrap-around.
  - On grant g: ack[g] = 1 for that cycle only; msg_row <= req slice g; rr_ptr <= (g+1) mod NREQ; state <= MSG; msg_cnt <= 0.
  - Request beats rotation: if grant and rotation expiry coincide, grant is taken, page does not advance, rot_cnt <= 0.
- MSG:
  - row_A/row_B = captured message. Later changes on req_row_* are ignored.
  - msg_active = 1. rot_cnt is held at 0. No preemption; other req stay pending with ack = 0.
  - At msg_cnt == MSG_CYC-1:
    - If any req is set, grant the next requester directly (MSG -> MSG, ack pulse, new text on the next edge).
    - Otherwise state <= ROTATE; rows return to the current page on the next edge.
  - A message is therefore visible for exactly MSG_CYC cycles.
- Requester rules:
  - req must stay high until ack. Dropping req before ack withdraws the request with no side effects.
  - req low in the ack cycle is legal.
  - req still high in the cycle after ack counts as a new request.
- Widths:
  - rot_cnt is $clog2(ROTATE_CYC) bits, msg_cnt is $clog2(MSG_CYC) bits.
  - rr_ptr is max(1,$clog2(NREQ)) bits, compared modulo NREQ.
- ack is combinational from state/req/rr_ptr/msg_cnt. All other outputs are registered.

Decomposition:
- Shared package lcd_pkg:
  - ROW_INIT constant.
  - sched_state_t enum {ROTATE, MSG}.
  - CHARS_PER_ROW = 16.
- Sub-module rr_arbiter:
  - Parameterised NREQ.
  - Inputs req and ptr; outputs any and one-hot/index grant.
  - Purely combinational; rr_ptr is stored in lcd_page_sched.

Test Plan (ROTATE_CYC=8, MSG_CYC=5, NREQ=2):
- Reset hold 3 cycles, then release with stat_row_a="STAT" padded -> rows = ROW_INIT during reset; row_A = stat_row_a 1 cycle after release; page = 0.
- Idle, hold_sw = 0 -> page toggles 0->1 at cycle 8 and 1->0 at cycle 16; rows follow score_row_* one cycle after each toggle.
- Set hold_sw = 1 at cycle 4 for 10 cycles, then clear -> page stays 0; toggle occurs 4 cycles after release.
- req = 2'b01 held until ack -> ack = 01 for exactly 1 cycle; then msg_active = 1 and rows = req slice 0 for 5 cycles; rows return to page 0 with rot_cnt restarted.
- req = 2'b11 simultaneously from reset -> ack = 01 first; ack = 10 on the expiry cycle 5 cycles later (back-to-back, no status frame); after that rr_ptr = 0.
- reset_n low 2 cycles into a message -> next edge shows rows = ROW_INIT, msg_active = 0, ack = 0; after release the pending req is granted with ack = 01.
